// File: rtl/dsync_filter_pkg.sv
// Shared helpers for the dsync_filter channel synchroniser.
package dsync_filter_pkg;

    // Counter width for a filter depth, never narrower than one bit.
    function automatic int cnt_width(input int filter);
        return (filter <= 1) ? 1 : $clog2(filter);
    endfunction

endpackage

// File: rtl/dsync_filter_ch.sv
// One channel: sync chain, stability filter and registered edge pulses.
module dsync_filter_ch
    import dsync_filter_pkg::*;
#(
    parameter int   STAGE   = 2,
    parameter int   FILTER  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(FILTER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

    // Pure flop chain, nothing between stages, so the metastability tools can see it.
    (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGE-1:0] s;

    logic             s_o;
    logic [CNT_W-1:0] cnt;
    logic             q_next;

    assign s_o = s[STAGE-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= {STAGE{RST_VAL}};
        else     s <= {s[STAGE-2:0], d};
    end

    always_comb begin
        q_next = q;
        if (s_o != q && cnt == CNT_LAST) q_next = s_o;
    end

    // A matching cycle always clears the count, including when it sits at CNT_LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            q    <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            if (s_o == q || cnt == CNT_LAST) cnt <= '0;
            else                             cnt <= cnt + 1'b1;
            q    <= q_next;
            rise <= ~q & q_next;
            fall <= q & ~q_next;
        end
    end

endmodule

// File: rtl/dsync_filter.sv
// Multi-channel filtered synchroniser for noisy asynchronous inputs.
module dsync_filter
    import dsync_filter_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               STAGE   = 2,
    parameter int               FILTER  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        dsync_filter_ch #(
            .STAGE  (STAGE),
            .FILTER (FILTER),
            .RST_VAL(RST_VAL[i])
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .d   (D[i]),
            .q   (Q[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end

    // OR of registered pulses, so it lines up with rise/fall in the same cycle.
    assign any_edge = |(rise | fall);

endmodule
